// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the program counter, presents the word index
// to a combinational instruction memory, and captures each returned word with
// its byte PC into a 2-entry buffer that decode drains through a valid/ready
// handshake. A redirect from execute flushes the buffer and restarts fetch at
// the new target; the target instruction reaches decode two cycles later.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target loads pc, raises the
//               sticky fetch_misaligned flag and halts fetch until an aligned
//               redirect (or reset) arrives.
//   undefined : redirect targets are forced word-aligned; fetch_misaligned is
//               tied 0 and the halt state is never entered.
//
// Parameters
//   RESET_PC          PC loaded on reset.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous active-high reset
//   imem_addr   [31:0] word index to instruction memory ({2'b00, pc[31:2]})
//   imem_data   [31:0] instruction word for imem_addr (same cycle)
//   redirect_valid    one-cycle restart request
//   redirect_pc [31:0] byte address of the restart target
//   dec_valid         buffer head holds a valid instruction
//   dec_instr   [31:0] instruction at the buffer head
//   dec_pc      [31:0] byte PC of dec_instr
//   dec_ready         decode accepts the head this cycle
//   fetch_misaligned  sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic        fetch_misaligned
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_buf_pc    [2];
  logic [31:0] r_buf_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_count_nxt;
  logic        w_redirect_misaligned;
  logic [31:0] w_redirect_target;

  // Redirect target handling depends on whether misaligned targets trap.
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        r_misaligned;

  assign w_redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_target     = redirect_pc;
  assign fetch_misaligned      = r_misaligned;

  // Sticky flag: set by a misaligned redirect, cleared by the next aligned one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      r_misaligned <= w_redirect_misaligned;
    end
  end
`else
  // Low target bits are dropped; keep them visibly consumed.
  logic        w_unused_redirect_lsbs;

  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];
  assign w_redirect_misaligned  = 1'b0;
  assign w_redirect_target      = {redirect_pc[31:2], 2'b00};
  assign fetch_misaligned       = 1'b0;
`endif

  // Decode-facing view of the buffer head.
  assign dec_valid = (r_count != 2'd0);
  assign dec_instr = r_buf_instr[r_rd_ptr];
  assign dec_pc    = r_buf_pc[r_rd_ptr];

  // imem_addr is a pure function of the pc register, so dec_ready never
  // reaches the memory address combinationally.
  assign imem_addr = {2'b00, r_pc[31:2]};

  // A redirect voids any handshake in the same cycle and suppresses the push.
  always_comb begin
    w_pop  = dec_valid && dec_ready && !redirect_valid;
    w_push = (r_state == S_RUN) && !redirect_valid &&
             ((r_count < 2'd2) || w_pop);
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // FSM: next state only changes on redirect.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = w_redirect_misaligned ? S_HALT : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // pc, buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (redirect_valid) begin
      r_pc     <= w_redirect_target;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
    end
  end

  // Buffer storage: cleared on reset so the head reads 0/0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_pc[i]    <= 32'd0;
        r_buf_instr[i] <= 32'd0;
      end
    end else if (w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_pc;
      r_buf_instr[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. Memory word k holds 32'h1000_0000 + k. The
// expected fetch stream (byte PCs) is queued as stimulus is driven; a monitor
// pops and compares an entry on every accepted decode handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_pc[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_valid        (dec_valid),
    .dec_instr        (dec_instr),
    .dec_pc           (dec_pc),
    .dec_ready        (dec_ready),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign imem_data = 32'h1000_0000 + imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sb_pc.push_back(start + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs change 1 time unit after the rising edge, so
  // the falling edge sees the values the next rising edge will act on.
  always @(negedge clk) begin
    logic [31:0] p;
    if (!reset && dec_valid && dec_ready && !redirect_valid) begin
      chk("sb_has_entry", {31'd0, sb_pc.size() != 0}, 32'd1);
      if (sb_pc.size() != 0) begin
        p = sb_pc.pop_front();
        chk("sb_pc", dec_pc, p);
        chk("sb_instr", dec_instr, 32'h1000_0000 + {2'b00, p[31:2]});
      end
    end
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    dec_ready      = 1'b1;
    repeat (3) step();

    // Streaming from reset with decode always ready.
    sb_push(32'h0, 3);
    reset = 1'b0;
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_misaligned", {31'd0, fetch_misaligned}, 32'd0);
    step();
    chk("c1_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("c1_dec_pc", dec_pc, 32'd0);
    repeat (3) step();
    reset     = 1'b1;
    dec_ready = 1'b0;

    // Backpressure: decode stalled for 5 cycles after reset.
    step();
    reset = 1'b0;
    sb_push(32'h0, 4);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_dec_pc", dec_pc, 32'd0);
      chk("stall_dec_instr", dec_instr, 32'h1000_0000);
    end
    chk("stall_imem_addr", imem_addr, 32'd2);
    chk("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
    step();
    dec_ready = 1'b1;
    repeat (4) step();

    // Redirect to 0x40 with a full buffer and decode ready.
    chk("pre_redir_imem_addr", imem_addr, 32'd6);
    chk("pre_redir_head", dec_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    sb_push(32'h40, 3);
    step();
    redirect_valid = 1'b0;
    chk("redir_n1_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("redir_n1_imem_addr", imem_addr, 32'h10);
    step();
    chk("redir_n2_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("redir_n2_dec_pc", dec_pc, 32'h40);
    chk("redir_n2_dec_instr", dec_instr, 32'h1000_0010);
    repeat (3) step();

    // Reset and redirect in the same cycle: reset wins.
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    dec_ready      = 1'b0;
    step();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    chk("rst_redir_imem_addr", imem_addr, 32'd0);
    chk("rst_redir_dec_valid", {31'd0, dec_valid}, 32'd0);
    sb_push(32'h0, 1);
    dec_ready = 1'b1;
    step();
    chk("rst_redir_dec_pc", dec_pc, 32'd0);
    step();

    // PC wrap from 0xFFFF_FFFC to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    sb_push(32'hFFFF_FFFC, 3);
    step();
    redirect_valid = 1'b0;
    chk("wrap_dec_valid_n1", {31'd0, dec_valid}, 32'd0);
    chk("wrap_imem_addr", imem_addr, 32'h3FFF_FFFF);
    step();
    step();
    chk("wrap_no_stall", {31'd0, dec_valid}, 32'd1);
    chk("wrap_dec_pc", dec_pc, 32'd0);
    step();
    step();

    // Misaligned redirect to 0x42.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
`ifdef FETCH_MISALIGN_TRAP_EN
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
      chk("mis_dec_valid", {31'd0, dec_valid}, 32'd0);
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h44;
    sb_push(32'h44, 1);
    step();
    redirect_valid = 1'b0;
    chk("mis_clear_flag", {31'd0, fetch_misaligned}, 32'd0);
    chk("mis_clear_imem_addr", imem_addr, 32'h11);
    step();
    chk("mis_resume_dec_pc", dec_pc, 32'h44);
    step();
    dec_ready = 1'b0;
`else
    sb_push(32'h40, 2);
    step();
    redirect_valid = 1'b0;
    chk("mis_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("mis_flag", {31'd0, fetch_misaligned}, 32'd0);
    chk("mis_imem_addr", imem_addr, 32'h10);
    step();
    chk("mis_resume_dec_pc", dec_pc, 32'h40);
    step();
    step();
    dec_ready = 1'b0;
    chk("mis_flag_after", {31'd0, fetch_misaligned}, 32'd0);
`endif

    repeat (2) step();
    chk("sb_drained", 32'(sb_pc.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core: owns the program counter, drives the word address into the combinational instruction memory, and captures each returned instruction with its PC into a 2-entry buffer. Decode pulls instructions through a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the new target. The block sits directly upstream of the instruction memory and directly upstream of decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  word index to instruction memory, `{2'b00, pc[31:2]}`.
- imem_data  input  32  instruction word; combinational function of imem_addr in the same cycle.
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  byte address of the redirect target.
- dec_valid  output  1  buffer head holds a valid instruction.
- dec_instr  output  32  instruction at the buffer head.
- dec_pc  output  32  byte PC of dec_instr.
- dec_ready  input  1  decode accepts the head this cycle.
- fetch_misaligned  output  1  sticky misaligned-target flag. Tied 0 unless FETCH_MISALIGN_TRAP_EN is defined.

## Operation
- State: pc (32), 2-entry FIFO of {pc, instr} with rd_ptr, wr_ptr and count (0..2), FSM {S_RUN, S_HALT}.
- Pop: `pop = dec_valid && dec_ready`. `dec_valid = (count != 0)`. dec_instr and dec_pc come from the head entry.
- Push (S_RUN only): `push = (count < 2) || pop`. On push, write {pc, imem_data}, then `pc <= pc + 4`.
  - pc wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Full with no pop: pc holds, imem_addr holds, no entry is lost or duplicated.
- Push and pop together: count is unchanged. With count 2, this gives full throughput of 1 instruction/cycle.
- Redirect (redirect_valid=1) takes priority over push and pop:
  - count, rd_ptr and wr_ptr go to 0.
  - `pc <= redirect_pc`, and the FSM returns to S_RUN.
  - No push happens that cycle.
  - A decode handshake in the same cycle is void; decode also discards it.
- Reset overrides redirect and every other input.
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC>>2.
  - count = 0, dec_valid = 0.
  - dec_instr = 0, dec_pc = 0 (all buffer entries cleared).
  - FSM = S_RUN, fetch_misaligned = 0.
- S_HALT: no push and pc frozen. Pops still drain the buffer. Exited only by redirect or reset.

## Timing
- Fetch-to-decode latency is 1 cycle. An instruction fetched in cycle N (imem_addr = pc) is presented with dec_valid=1 in cycle N+1.
- Reset released before cycle 0: cycle 0 fetches RESET_PC, and cycle 1 presents it.
- Redirect in cycle N:
  - cycle N+1: dec_valid=0, imem_addr = redirect_pc>>2.
  - cycle N+2: target instruction is presented.
- Redirect penalty is 2 cycles.
- dec_* outputs are stable while `dec_valid && !dec_ready`.
- No combinational path from dec_ready to imem_addr. The push decision may use pop, but pc updates only at the clock edge.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with `redirect_pc[1:0] != 0` still loads pc.
  - It sets fetch_misaligned=1 (sticky) and enters S_HALT, with no fetch.
  - The next aligned redirect clears fetch_misaligned and returns to S_RUN.
  - Reset also clears it.
- FETCH_MISALIGN_TRAP_EN undefined:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - fetch_misaligned is constant 0 and S_HALT is unreachable.

## Test plan
- Reset with RESET_PC=0, memory word k = 32'h1000_0000+k, dec_ready=1 -> dec_valid rises cycle 1; dec_pc/dec_instr = 0/1000_0000, 4/1000_0001, 8/1000_0002 on consecutive cycles.
- dec_ready=0 for 5 cycles after reset -> count saturates at 2, imem_addr holds 2. Release -> words 0,1,2,3 delivered in order, none duplicated or skipped.
- Redirect to 32'h40 while the buffer holds 2 entries and dec_ready=1 -> dec_valid=0 next cycle; cycle N+2 shows dec_pc=0x40, instr word 16.
- Redirect asserted in the same cycle as reset -> post-reset fetch starts at RESET_PC, not the redirect target.
- pc = 32'hFFFF_FFFC, dec_ready=1 -> next dec_pc is 0, no stall.
- Misaligned redirect to 32'h42:
  - With FETCH_MISALIGN_TRAP_EN: fetch_misaligned=1 and dec_valid stays 0 until a redirect to 0x44, which clears the flag and fetches 0x44.
  - Without the macro: fetch resumes at 0x40 and fetch_misaligned stays 0.
